// File: rtl/led_status_ctrl.sv
// Status-LED output stage: off / solid / glow passthrough / blink-code sequencer.
// Optional macro LED_CODE_REPEAT_EN: blink code repeats forever instead of playing once.
module led_status_ctrl #(
    parameter logic [23:0] TICK_DIV  = 24'd2700000,
    parameter logic [7:0]  ON_TICKS  = 8'd4,
    parameter logic [7:0]  OFF_TICKS = 8'd4,
    parameter logic [7:0]  GAP_TICKS = 8'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       glow_in,
    input  logic [1:0] mode,
    input  logic [3:0] code,
    output logic       led,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] presc;
    logic [7:0]  tick_cnt;
    logic [7:0]  tick_lim;
    logic [3:0]  blink_cnt;
    logic [3:0]  code_lat;
    logic        blink_mode;
    logic        tick;
    logic        phase_done;
    logic        restart;
    logic        led_nxt;

    assign blink_mode = (mode == 2'd3);
    assign tick       = (presc == TICK_DIV - 24'd1);
    assign phase_done = tick && (tick_cnt == tick_lim);

    always_comb begin
        tick_lim = 8'd0;
        case (state)
            S_ON:    tick_lim = ON_TICKS - 8'd1;
            S_OFF:   tick_lim = OFF_TICKS - 8'd1;
            S_GAP:   tick_lim = GAP_TICKS - 8'd1;
            default: tick_lim = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!blink_mode) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = (code != 4'd0) ? S_ON : S_GAP;
                S_ON: begin
                    if (phase_done)
                        state_nxt = (blink_cnt + 4'd1 == code_lat) ? S_GAP : S_OFF;
                end
                S_OFF: begin
                    if (phase_done) state_nxt = S_ON;
                end
                S_GAP: begin
`ifdef LED_CODE_REPEAT_EN
                    if (phase_done) state_nxt = S_IDLE;
`else
                    if (phase_done) state_nxt = S_DONE;
`endif
                end
                S_DONE: begin
                    if (code != code_lat) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Timing restarts from zero on every state entry and stays parked outside ON/OFF/GAP.
    assign restart = !blink_mode || (state_nxt != state) ||
                     (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= 24'd0;
            tick_cnt <= 8'd0;
        end else if (restart) begin
            presc    <= 24'd0;
            tick_cnt <= 8'd0;
        end else if (tick) begin
            presc    <= 24'd0;
            tick_cnt <= tick_cnt + 8'd1;
        end else begin
            presc    <= presc + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= 4'd0;
            code_lat  <= 4'd0;
        end else begin
            if (state == S_IDLE) code_lat <= code;
            if (!blink_mode || state == S_IDLE)
                blink_cnt <= 4'd0;
            else if (state == S_ON && phase_done)
                blink_cnt <= blink_cnt + 4'd1;
        end
    end

    always_comb begin
        busy    = (state == S_ON) || (state == S_OFF) || (state == S_GAP);
        led_nxt = 1'b0;
        case (mode)
            2'd0:    led_nxt = 1'b0;
            2'd1:    led_nxt = 1'b1;
            2'd2:    led_nxt = glow_in;
            default: led_nxt = (state == S_ON);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= 1'b0;
        else       led <= led_nxt;
    end

endmodule
